// File: rtl/adiabatic_pclk_sequencer_if.sv
// Bundle between the power-clock sequencer and its controller / level drivers.
//   run      controller -> sequencer  level: 1 = generate clocks, 0 = drain and stop
//   div      controller -> sequencer  step stretch (each step lasts div+1 clk cycles)
//   lvl_pos  sequencer -> driver      phase k clkpos tap at [k*STEP_W +: STEP_W]
//   lvl_neg  sequencer -> driver      phase k clkneg tap (MAX - lvl_pos)
//   active   sequencer -> controller  phase k currently cycling
//   q_tick   sequencer -> controller  pulse on the first cycle of every quarter
//   busy     sequencer -> controller  sequencer not idle
interface adiabatic_pclk_sequencer_if #(
    parameter int STEP_W = 2,
    parameter int DIV_W  = 4
);
    logic                  run;
    logic [DIV_W-1:0]      div;
    logic [4*STEP_W-1:0]   lvl_pos;
    logic [4*STEP_W-1:0]   lvl_neg;
    logic [3:0]            active;
    logic                  q_tick;
    logic                  busy;

    modport master (output run, div, input lvl_pos, lvl_neg, active, q_tick, busy);
    modport slave  (input run, div, output lvl_pos, lvl_neg, active, q_tick, busy);
endinterface

// File: rtl/adiabatic_pclk_sequencer.sv
// 4-phase stepwise-charging power-clock sequencer for the adiabatic datapath.
// Each phase walks a trapezoid RISE/HOLD/FALL/WAIT, phase k lagging phase 0 by
// k quarters. Phases are switched on only at RISE entry and off only at FALL
// exit, so no gate ever sees a partial ramp (reset excepted).
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-high
//   bus    slave side of adiabatic_pclk_sequencer_if (run, div in;
//          lvl_pos, lvl_neg, active, q_tick, busy out - all registered)
module adiabatic_pclk_sequencer #(
    parameter int STEP_W = 2,
    parameter int DIV_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    adiabatic_pclk_sequencer_if.slave  bus
);
    localparam logic [STEP_W-1:0] MAX = '1;
    localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, n_state;
    logic [DIV_W-1:0]    div_r, n_div, d, n_d;
    logic [STEP_W-1:0]   s, n_s;
    logic [1:0]          q, n_q, lq_g, lq;
    logic [3:0]          act, n_act;
    logic                n_tick;
    logic [STEP_W-1:0]   lv;
    logic [4*STEP_W-1:0] n_pos, n_neg;
    logic [4*STEP_W-1:0] pos_r, neg_r;
    logic                tick_r, busy_r;

    // Next-state: FSM, step/quarter counters and phase gating.
    always_comb begin
        n_state = state;
        n_div   = div_r;
        n_d     = d;
        n_s     = s;
        n_q     = q;
        n_act   = act;
        n_tick  = 1'b0;
        lq_g    = '0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    n_state = RUN;
                    n_div   = bus.div;
                    n_d     = '0;
                    n_s     = '0;
                    n_q     = '0;
                    n_act   = 4'b0001;
                end
            end
            default: begin
                if (d == div_r) begin
                    n_d = '0;
                    if (s == MAX - ONE) begin
                        n_s    = '0;
                        n_q    = q + 2'd1;
                        n_tick = 1'b1;
                        // Gating decisions happen only at quarter boundaries:
                        // entering RISE arms a phase (RUN only), leaving FALL
                        // in DRAIN disarms it.
                        for (int unsigned k = 0; k < 4; k++) begin
                            lq_g = n_q - 2'(k);
                            if (lq_g == 2'd0)
                                n_act[k] = (state == RUN);
                            else if (lq_g == 2'd3 && state == DRAIN)
                                n_act[k] = 1'b0;
                        end
                    end else begin
                        n_s = s + ONE;
                    end
                end else begin
                    n_d = d + DIV_W'(1);
                end
                if (state == RUN) begin
                    if (!bus.run) n_state = DRAIN;
                end else if (bus.run) begin
                    n_state = RUN;
                end else if (act == 4'b0000) begin
                    n_state = IDLE;
                end
            end
        endcase
    end

    // Levels are derived from the next counter values so the registered
    // outputs line up with the counters they describe.
    always_comb begin
        n_pos = '0;
        n_neg = '0;
        lq    = '0;
        lv    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            lq = n_q - 2'(k);
            case (lq)
                2'd0:    lv = n_s + ONE;
                2'd1:    lv = MAX;
                2'd2:    lv = MAX - ONE - n_s;
                default: lv = '0;
            endcase
            if (!n_act[k]) lv = '0;
            n_pos[k*STEP_W +: STEP_W] = lv;
            n_neg[k*STEP_W +: STEP_W] = MAX - lv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            div_r  <= '0;
            d      <= '0;
            s      <= '0;
            q      <= '0;
            act    <= '0;
            tick_r <= 1'b0;
            busy_r <= 1'b0;
            pos_r  <= '0;
            neg_r  <= '1;
        end else begin
            state  <= n_state;
            div_r  <= n_div;
            d      <= n_d;
            s      <= n_s;
            q      <= n_q;
            act    <= n_act;
            tick_r <= n_tick;
            busy_r <= (n_state != IDLE);
            pos_r  <= n_pos;
            neg_r  <= n_neg;
        end
    end

    assign bus.lvl_pos = pos_r;
    assign bus.lvl_neg = neg_r;
    assign bus.active  = act;
    assign bus.q_tick  = tick_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Self-checking bench for adiabatic_pclk_sequencer (STEP_W=2, DIV_W=4).
// The reference model tracks elapsed time since start and derives quarter,
// step and levels arithmetically from it.
module tb_adiabatic_pclk_sequencer;
    localparam int unsigned MAXV = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    adiabatic_pclk_sequencer_if #(.STEP_W(2), .DIV_W(4)) bus ();

    adiabatic_pclk_sequencer #(.STEP_W(2), .DIV_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_mode = 0;   // 0 idle, 1 run, 2 drain
    int unsigned m_t    = 0;   // cycles elapsed since start
    int unsigned m_div  = 0;
    logic [3:0]  exp_act  = '0;
    logic [7:0]  exp_pos  = '0;
    logic [7:0]  exp_neg  = 8'hFF;
    logic        exp_tick = 1'b0;
    logic        exp_busy = 1'b0;

    task automatic model_step(input logic rst, input logic run_i, input int unsigned div_i);
        int unsigned qlen, qq, ss, lq, lv;
        logic [3:0]  old_act;
        int          prev;
        exp_tick = 1'b0;
        if (rst) begin
            m_mode  = 0;
            exp_act = '0;
        end else if (m_mode == 0) begin
            if (run_i) begin
                m_mode  = 1;
                m_div   = div_i;
                m_t     = 0;
                exp_act = 4'b0001;
            end
        end else begin
            prev    = m_mode;
            old_act = exp_act;
            m_t++;
            qlen = MAXV * (m_div + 1);
            if (m_t % qlen == 0) begin
                exp_tick = 1'b1;
                qq = (m_t / qlen) % 4;
                for (int k = 0; k < 4; k++) begin
                    lq = (qq + 4 - k) % 4;
                    if (lq == 0) exp_act[k] = (prev == 1);
                    else if (lq == 3 && prev == 2) exp_act[k] = 1'b0;
                end
            end
            if (prev == 1) begin
                if (!run_i) m_mode = 2;
            end else if (run_i) begin
                m_mode = 1;
            end else if (old_act == 4'b0000) begin
                m_mode = 0;
            end
        end
        qlen = MAXV * (m_div + 1);
        qq   = (m_t / qlen) % 4;
        ss   = (m_t % qlen) / (m_div + 1);
        for (int k = 0; k < 4; k++) begin
            lq = (qq + 4 - k) % 4;
            if (lq == 0)      lv = ss + 1;
            else if (lq == 1) lv = MAXV;
            else if (lq == 2) lv = MAXV - 1 - ss;
            else              lv = 0;
            if (!exp_act[k]) lv = 0;
            exp_pos[k*2 +: 2] = 2'(lv);
            exp_neg[k*2 +: 2] = 2'(MAXV - lv);
        end
        exp_busy = (m_mode != 0);
    endtask

    // One clock: model follows the DUT edge; caller samples at negedge.
    task automatic step();
        @(posedge clk);
        model_step(reset, bus.run, int'(bus.div));
        @(negedge clk);
    endtask

    task automatic drain_to_idle(input string name);
        bus.run = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            total++;
            if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy} !==
                {exp_pos, exp_neg, exp_act, exp_tick, exp_busy}) begin
                bad++;
                $display("FAIL %s_drain: got pos=%h neg=%h act=%b tick=%b busy=%b want pos=%h neg=%h act=%b tick=%b busy=%b",
                         name, bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy,
                         exp_pos, exp_neg, exp_act, exp_tick, exp_busy);
            end
            if (!bus.busy) break;
        end
        total++;
        if (bus.busy !== 1'b0 || bus.lvl_pos !== 8'h00) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b pos=%h want busy=0 pos=00", name, bus.busy, bus.lvl_pos);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.run = 1'b0; bus.div = '0;
        step(); step();
        total++;
        if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy} !== {8'h00, 8'hFF, 4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got pos=%h neg=%h act=%b tick=%b busy=%b want pos=00 neg=ff act=0000 tick=0 busy=0",
                     bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_startup_drain();
        int unsigned p0_seq[12] = '{1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0, 0};
        logic [3:0]  act_want;
        logic        tick_want;
        bus.run = 1'b1; bus.div = 4'd0;
        for (int n = 1; n <= 20; n++) begin
            step();
            total++;
            if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy} !==
                {exp_pos, exp_neg, exp_act, exp_tick, exp_busy}) begin
                bad++;
                $display("FAIL startup_model c%0d: got pos=%h neg=%h act=%b tick=%b busy=%b want pos=%h neg=%h act=%b tick=%b busy=%b",
                         n, bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy,
                         exp_pos, exp_neg, exp_act, exp_tick, exp_busy);
            end
            total++;
            if (int'(bus.lvl_pos[1:0]) != int'(p0_seq[(n-1) % 12])) begin
                bad++;
                $display("FAIL startup_p0 c%0d: got %0d want %0d", n, bus.lvl_pos[1:0], p0_seq[(n-1) % 12]);
            end
            if (n <= 6) begin
                total++;
                if (int'(bus.lvl_pos[3:2]) != ((n <= 3) ? 0 : n - 3)) begin
                    bad++;
                    $display("FAIL startup_p1 c%0d: got %0d want %0d", n, bus.lvl_pos[3:2], (n <= 3) ? 0 : n - 3);
                end
            end
            if (n == 1 || n == 4 || n == 7 || n == 10) begin
                act_want = (n == 1) ? 4'b0001 : (n == 4) ? 4'b0011 : (n == 7) ? 4'b0111 : 4'b1111;
                total++;
                if (bus.active !== act_want) begin
                    bad++;
                    $display("FAIL startup_active c%0d: got %b want %b", n, bus.active, act_want);
                end
            end
            tick_want = (n >= 4) && ((n - 1) % 3 == 0);
            total++;
            if (bus.q_tick !== tick_want) begin
                bad++;
                $display("FAIL startup_tick c%0d: got %b want %b", n, bus.q_tick, tick_want);
            end
        end
        drain_to_idle("t2");
        bus.run = 1'b1;
        step();
        total++;
        if (bus.lvl_pos !== 8'h01 || bus.active !== 4'b0001) begin
            bad++;
            $display("FAIL restart: got pos=%h act=%b want pos=01 act=0001", bus.lvl_pos, bus.active);
        end
        drain_to_idle("restart");
    endtask

    task automatic test_stretch();
        int unsigned want;
        reset = 1'b1; step(); reset = 1'b0;
        bus.run = 1'b1; bus.div = 4'd2;
        for (int n = 1; n <= 40; n++) begin
            step();
            total++;
            if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy} !==
                {exp_pos, exp_neg, exp_act, exp_tick, exp_busy}) begin
                bad++;
                $display("FAIL stretch_model c%0d: got pos=%h neg=%h act=%b tick=%b busy=%b want pos=%h neg=%h act=%b tick=%b busy=%b",
                         n, bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy,
                         exp_pos, exp_neg, exp_act, exp_tick, exp_busy);
            end
            if (n <= 18) begin
                want = (n <= 9) ? (n - 1) / 3 + 1 : 3;
                total++;
                if (int'(bus.lvl_pos[1:0]) != int'(want)) begin
                    bad++;
                    $display("FAIL stretch_p0 c%0d: got %0d want %0d", n, bus.lvl_pos[1:0], want);
                end
            end
            total++;
            if (bus.q_tick !== ((n > 1) && ((n - 1) % 9 == 0))) begin
                bad++;
                $display("FAIL stretch_tick c%0d: got %b want %b", n, bus.q_tick, (n > 1) && ((n - 1) % 9 == 0));
            end
            if (n == 5) bus.div = 4'd0;
        end
        drain_to_idle("t3");
    endtask

    task automatic test_reset_mid_hold();
        reset = 1'b1; step(); reset = 1'b0;
        bus.run = 1'b1; bus.div = 4'd0;
        for (int n = 1; n <= 5; n++) step();
        total++;
        if (bus.lvl_pos[1:0] !== 2'd3) begin
            bad++;
            $display("FAIL hold_level: got %0d want 3", bus.lvl_pos[1:0]);
        end
        reset = 1'b1;
        step();
        total++;
        if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.busy} !== {8'h00, 8'hFF, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got pos=%h neg=%h act=%b busy=%b want pos=00 neg=ff act=0000 busy=0",
                     bus.lvl_pos, bus.lvl_neg, bus.active, bus.busy);
        end
        reset = 1'b0; bus.run = 1'b0;
        step();
    endtask

    task automatic test_run_glitch();
        logic [7:0] ref_pos[1:30];
        reset = 1'b1; step(); reset = 1'b0;
        bus.run = 1'b1; bus.div = 4'd0;
        for (int n = 1; n <= 30; n++) begin
            step();
            ref_pos[n] = bus.lvl_pos;
        end
        reset = 1'b1; bus.run = 1'b0; step(); reset = 1'b0;
        bus.run = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            total++;
            if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy} !==
                {exp_pos, exp_neg, exp_act, exp_tick, exp_busy}) begin
                bad++;
                $display("FAIL glitch_model c%0d: got pos=%h neg=%h act=%b tick=%b busy=%b want pos=%h neg=%h act=%b tick=%b busy=%b",
                         n, bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy,
                         exp_pos, exp_neg, exp_act, exp_tick, exp_busy);
            end
            total++;
            if (bus.lvl_pos !== ref_pos[n] || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL glitch_seq c%0d: got pos=%h busy=%b want pos=%h busy=1", n, bus.lvl_pos, bus.busy, ref_pos[n]);
            end
            if (n == 13) bus.run = 1'b0;
            if (n == 14) bus.run = 1'b1;
        end
        drain_to_idle("t5");
    endtask

    task automatic test_random();
        logic [7:0] prev_pos;
        logic       was_reset;
        int         a, b;
        prev_pos  = bus.lvl_pos;
        was_reset = 1'b1;
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 11) == 0) bus.run = ~bus.run;
            bus.div = 4'($urandom_range(0, 3));
            step();
            total++;
            if ({bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy} !==
                {exp_pos, exp_neg, exp_act, exp_tick, exp_busy}) begin
                bad++;
                $display("FAIL random_model c%0d: got pos=%h neg=%h act=%b tick=%b busy=%b want pos=%h neg=%h act=%b tick=%b busy=%b",
                         n, bus.lvl_pos, bus.lvl_neg, bus.active, bus.q_tick, bus.busy,
                         exp_pos, exp_neg, exp_act, exp_tick, exp_busy);
            end
            for (int k = 0; k < 4; k++) begin
                a = int'(bus.lvl_pos[k*2 +: 2]);
                b = int'(prev_pos[k*2 +: 2]);
                total++;
                if (int'(bus.lvl_neg[k*2 +: 2]) != 3 - a) begin
                    bad++;
                    $display("FAIL neg_invariant c%0d p%0d: got neg=%0d want %0d", n, k, bus.lvl_neg[k*2 +: 2], 3 - a);
                end
                if (!was_reset && !reset) begin
                    total++;
                    if (a - b > 1 || b - a > 1) begin
                        bad++;
                        $display("FAIL slew c%0d p%0d: got step %0d->%0d want change <= 1", n, k, b, a);
                    end
                end
            end
            was_reset = reset;
            prev_pos  = bus.lvl_pos;
        end
        reset = 1'b0;
        drain_to_idle("random");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bus.run = 1'b0; bus.div = '0;
        test_reset();
        test_startup_drain();
        test_stretch();
        test_reset_mid_hold();
        test_run_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
